// File: rtl/ultra_sonic_pkg.sv
// Shared types and constants for the ultrasonic ranger filter stage.
package ultra_sonic_pkg;

    localparam int SAMPLE_WIDTH = 16;

    typedef enum logic {
        FILL,
        RUN
    } filt_state_t;

endpackage

// File: rtl/ultra_sonic_ring.sv
// Sample window storage: one write per accepted sample, oldest entry read at wr_ptr.
module ultra_sonic_ring
    import ultra_sonic_pkg::*;
#(
    parameter int DATA_WIDTH = SAMPLE_WIDTH,
    parameter int WIN_LOG2   = 2
) (
    input  logic                  clk,
    input  logic                  reset_l,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] oldest,
    output logic [WIN_LOG2-1:0]   wr_ptr
);

    localparam int DEPTH = 2 ** WIN_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
        end
    end

    // Slot about to be overwritten holds the sample leaving the window.
    assign oldest = mem[wr_ptr];

endmodule

// File: rtl/ultra_sonic_filter.sv
// Moving-average filter with hysteresis proximity flag and silence timeout.
module ultra_sonic_filter
    import ultra_sonic_pkg::*;
#(
    parameter int                    DATA_WIDTH    = SAMPLE_WIDTH,
    parameter int                    WIN_LOG2      = 2,
    parameter int                    TIMEOUT_WIDTH = 23,
    parameter logic [DATA_WIDTH-1:0] NEAR_THRESH   = 16'd150,
    parameter logic [DATA_WIDTH-1:0] HYST          = 16'd16
) (
    input  logic                  clk,
    input  logic                  reset_l,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  sample_valid,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] avg_data,
    output logic                  avg_valid,
    output logic                  near,
    output logic                  sensor_timeout
);

    localparam int SW = DATA_WIDTH + WIN_LOG2;

    filt_state_t               state;
    filt_state_t               state_next;
    logic [SW-1:0]             sum;
    logic [SW-1:0]             sum_next;
    logic [WIN_LOG2-1:0]       fill_cnt;
    logic [TIMEOUT_WIDTH-1:0]  silence_cnt;
    logic [DATA_WIDTH-1:0]     oldest;
    logic [DATA_WIDTH-1:0]     oldest_term;
    logic [DATA_WIDTH-1:0]     avg_next;
    logic [WIN_LOG2-1:0]       wr_ptr;
    logic                      accept;
    logic                      timeout_hit;
    logic                      flush;
    logic                      fill_last;
    logic                      produce;
    logic                      sil_max;
    logic [DATA_WIDTH:0]       thresh_lo;
    logic [DATA_WIDTH:0]       thresh_hi;

    assign accept      = sample_valid & ~clear;
    assign sil_max     = &silence_cnt;
    // Fires only on the edge the counter becomes all-ones; a sample pre-empts it.
    assign timeout_hit = ~sample_valid &
                         (silence_cnt == {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0});
    assign flush       = clear | timeout_hit;
    assign fill_last   = (state == FILL) && (fill_cnt == '1);
    assign produce     = accept && ((state == RUN) || fill_last);
    assign oldest_term = (state == RUN) ? oldest : '0;
    assign sum_next    = sum + {{WIN_LOG2{1'b0}}, sample_data}
                             - {{WIN_LOG2{1'b0}}, oldest_term};
    assign avg_next    = sum_next[SW-1:WIN_LOG2];
    assign thresh_lo   = {1'b0, NEAR_THRESH};
    assign thresh_hi   = {1'b0, NEAR_THRESH} + {1'b0, HYST};

    ultra_sonic_ring #(
        .DATA_WIDTH (DATA_WIDTH),
        .WIN_LOG2   (WIN_LOG2)
    ) u_ring (
        .clk     (clk),
        .reset_l (reset_l),
        .wr_en   (accept),
        .wr_data (sample_data),
        .flush   (flush),
        .oldest  (oldest),
        .wr_ptr  (wr_ptr)
    );

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = FILL;
        end else if (accept && fill_last) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            silence_cnt <= '0;
        end else if (sample_valid) begin
            silence_cnt <= '0;
        end else if (!sil_max) begin
            silence_cnt <= silence_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sum            <= '0;
            fill_cnt       <= '0;
            avg_data       <= '0;
            avg_valid      <= 1'b0;
            near           <= 1'b0;
            sensor_timeout <= 1'b0;
        end else if (flush) begin
            sum       <= '0;
            fill_cnt  <= '0;
            avg_valid <= 1'b0;
            near      <= 1'b0;
            if (timeout_hit) begin
                sensor_timeout <= 1'b1;
            end
        end else if (accept) begin
            sum            <= sum_next;
            sensor_timeout <= 1'b0;
            avg_valid      <= produce;
            if (state == FILL) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (produce) begin
                avg_data <= avg_next;
                if ({1'b0, avg_next} < thresh_lo) begin
                    near <= 1'b1;
                end else if ({1'b0, avg_next} >= thresh_hi) begin
                    near <= 1'b0;
                end
            end
        end else begin
            avg_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ultra_sonic_filter.sv
// Directed and randomized checks of ultra_sonic_filter against a queue-based model.
module tb_ultra_sonic_filter;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic [15:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] avg_data;
    logic        avg_valid;
    logic        near;
    logic        sensor_timeout;

    int compared = 0;
    int mismatched = 0;

    int unsigned win[$];
    int          idle = 0;
    logic [15:0] exp_avg = '0;
    logic        exp_valid = 1'b0;
    logic        exp_near = 1'b0;
    logic        exp_tmo = 1'b0;

    always #5 clk = ~clk;

    ultra_sonic_filter #(
        .DATA_WIDTH    (16),
        .WIN_LOG2      (2),
        .TIMEOUT_WIDTH (8),
        .NEAR_THRESH   (16'd150),
        .HYST          (16'd16)
    ) dut (
        .clk            (clk),
        .reset_l        (reset_l),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .clear          (clear),
        .avg_data       (avg_data),
        .avg_valid      (avg_valid),
        .near           (near),
        .sensor_timeout (sensor_timeout)
    );

    task automatic chk(input string tag, input int unsigned obs,
                       input int unsigned exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        win.delete();
        idle      = 0;
        exp_avg   = '0;
        exp_valid = 1'b0;
        exp_near  = 1'b0;
        exp_tmo   = 1'b0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input logic v, input logic [15:0] d,
                              input logic c);
        int unsigned total;
        int          idle_n;
        logic        tmo_evt;
        idle_n    = v ? 0 : ((idle == 255) ? 255 : idle + 1);
        tmo_evt   = !v && idle != 255 && idle_n == 255;
        exp_valid = 1'b0;
        if (c || tmo_evt) begin
            win.delete();
            exp_near = 1'b0;
            if (tmo_evt) exp_tmo = 1'b1;
        end else if (v) begin
            exp_tmo = 1'b0;
            win.push_back(d);
            if (win.size() > 4) void'(win.pop_front());
            if (win.size() == 4) begin
                total = 0;
                foreach (win[i]) total += win[i];
                exp_avg   = 16'(total / 4);
                exp_valid = 1'b1;
                if (exp_avg < 150) exp_near = 1'b1;
                else if (exp_avg >= 166) exp_near = 1'b0;
            end
        end
        idle = idle_n;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".avg_valid"}, avg_valid, exp_valid);
        chk({tag, ".avg_data"}, avg_data, exp_avg);
        chk({tag, ".near"}, near, exp_near);
        chk({tag, ".timeout"}, sensor_timeout, exp_tmo);
    endtask

    task automatic cyc(input logic v, input logic [15:0] d, input logic c,
                       input string tag);
        sample_valid = v;
        sample_data  = d;
        clear        = c;
        @(posedge clk);
        model_edge(v, d, c);
        #1;
        sample_valid = 1'b0;
        clear        = 1'b0;
        check_all(tag);
    endtask

    task automatic gap(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'd0, 1'b0, tag);
    endtask

    task automatic spaced(input logic [15:0] d, input string tag);
        cyc(1'b1, d, 1'b0, tag);
        gap(9, tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk);
        #1;
        reset_l = 1'b1;

        // Fill with 100s; avg appears only on the 4th sample
        for (int i = 0; i < 3; i++) spaced(16'd100, "t1_fill");
        cyc(1'b1, 16'd100, 1'b0, "t1_4th");
        chk("t1_avg_valid", avg_valid, 1);
        chk("t1_avg", avg_data, 100);
        chk("t1_near", near, 1);
        gap(9, "t1_gap");

        spaced(16'd200, "t2");
        cyc(1'b1, 16'd170, 1'b0, "t2");
        chk("t2_avg142", avg_data, 142);
        gap(9, "t2");
        cyc(1'b1, 16'd170, 1'b0, "t2");
        chk("t2_avg160", avg_data, 160);
        chk("t2_near_hold", near, 1);
        gap(9, "t2");
        cyc(1'b1, 16'd170, 1'b0, "t2");
        chk("t2_avg177", avg_data, 177);
        chk("t2_near_clr", near, 0);

        // Pull near back high, then go silent
        for (int i = 0; i < 4; i++) cyc(1'b1, 16'd60, 1'b0, "t3_pre");
        chk("t3_pre_near", near, 1);
        gap(260, "t3_silence");
        chk("t3_timeout", sensor_timeout, 1);
        chk("t3_near", near, 0);
        chk("t3_avg_hold", avg_data, 60);
        for (int i = 0; i < 3; i++) spaced(16'd300, "t3_refill");
        chk("t3_tmo_cleared", sensor_timeout, 0);
        cyc(1'b1, 16'd300, 1'b0, "t3_4th");
        chk("t3_avg", avg_data, 300);

        cyc(1'b1, 16'd999, 1'b1, "t4_clr");
        chk("t4_no_valid", avg_valid, 0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 16'd50, 1'b0, "t4_fill");
        chk("t4_avg", avg_data, 50);

        cyc(1'b0, 16'd0, 1'b1, "t5_clr");
        cyc(1'b1, 16'd1, 1'b0, "t5");
        cyc(1'b1, 16'd2, 1'b0, "t5");
        cyc(1'b1, 16'd3, 1'b0, "t5");
        cyc(1'b1, 16'd5, 1'b0, "t5");
        chk("t5_avg2", avg_data, 2);
        cyc(1'b1, 16'd5, 1'b0, "t5");
        chk("t5_avg3", avg_data, 3);

        // Edge where silence would saturate: the sample wins
        gap(254, "t5b_gap");
        cyc(1'b1, 16'd7, 1'b0, "t5b_sample");
        chk("t5b_no_tmo", sensor_timeout, 0);

        cyc(1'b0, 16'd0, 1'b1, "t6_clr");
        cyc(1'b1, 16'd40, 1'b0, "t6");
        cyc(1'b1, 16'd40, 1'b0, "t6");
        #2;
        reset_l = 1'b0;
        #1;
        model_reset();
        check_all("t6_reset");
        @(posedge clk);
        #1;
        reset_l = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'd80, 1'b0, "t6_refill");
        cyc(1'b1, 16'd80, 1'b0, "t6_4th");
        chk("t6_valid", avg_valid, 1);
        chk("t6_avg", avg_data, 80);

        for (int i = 0; i < 3000; i++) begin
            logic        v;
            logic        c;
            logic [15:0] d;
            v = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 49) == 0);
            d = 16'($urandom_range(100, 230));
            if ($urandom_range(0, 15) == 0) d = 16'($urandom);
            if (i == 1500) gap(300, "rand_silence");
            cyc(v, d, c, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
